// File: rtl/xnor_pop_pkg.sv
// xnor_pop_pkg -- shared widths, FSM state encoding and popcount width helper.
// rev 1.0
`default_nettype none

package xnor_pop_pkg;

  localparam int POP_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_e;

  function automatic int pop_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xnor_popcount_stage.sv
// xnor_popcount_stage -- registered popcount of xnor(x, w), one cycle latency.
// rev 1.0
`default_nettype none

module xnor_popcount_stage
  import xnor_pop_pkg::*;
#(
  parameter int N = 256,
  localparam int CW = pop_width(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  w,
  output logic          out_valid,
  output logic [CW-1:0] count
);

  logic [N-1:0]  match;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;
  logic          valid_d;
  logic          valid_q;

  always_comb begin
    match   = ~(x ^ w);
    count_d = '0;
    for (int i = 0; i < N; i++) begin
      count_d = count_d + CW'(match[i]);
    end
    valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/xnor_neuron_sequencer.sv
// xnor_neuron_sequencer -- issues K chunk reads, accumulates XNOR popcounts, thresholds the sum.
// rev 1.0
`default_nettype none

module xnor_neuron_sequencer
  import xnor_pop_pkg::*;
#(
  parameter int N          = 256,
  parameter int CHUNKS_MAX = 8,
  parameter int AW         = 3,
  parameter int POP        = POP_W,
  parameter int RD_LAT     = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic [AW:0]    num_chunks,
  input  logic [POP-1:0] threshold,
  output logic           busy,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  input  logic [N-1:0]   rd_x,
  input  logic [N-1:0]   rd_w,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_bit,
  output logic [POP-1:0] out_sum
);

  localparam int          CW   = pop_width(N);
  localparam logic [AW:0] KMAX = (AW+1)'(CHUNKS_MAX);

  state_e            state_q, state_d;
  logic [AW:0]       k_q, k_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [POP-1:0]    thr_q, thr_d;
  logic [POP-1:0]    acc_q, acc_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic              pop_valid;
  logic [CW-1:0]     pop_count;
  logic [AW:0]       k_in;
  logic              start_acc;
  logic              last_issue;
  logic [POP:0]      acc_sum;

  assign k_in       = (num_chunks > KMAX) ? KMAX : num_chunks;
  assign start_acc  = (state_q == IDLE) && start;
  assign last_issue = ({1'b0, addr_q} == (k_q - 1'b1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (k_in == '0) ? RESULT : ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      // Reads are back to back, so an empty valid pipe with a pending count marks the last chunk.
      DRAIN:   if ((vld_q == '0) && pop_valid) state_d = RESULT;
      RESULT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    rd_en     = (state_q == ISSUE);
    rd_addr   = addr_q;
    out_valid = (state_q == RESULT);
    out_sum   = acc_q;
    out_bit   = (acc_q > thr_q);
  end

  always_comb begin
    k_d    = k_q;
    thr_d  = thr_q;
    if (start_acc) begin
      k_d   = k_in;
      thr_d = threshold;
    end
    addr_d  = ((state_q == ISSUE) && !last_issue) ? addr_q + 1'b1 : '0;
    vld_d   = (vld_q << 1) | RD_LAT'(rd_en);
    acc_sum = {1'b0, acc_q} + (POP+1)'(pop_count);
    acc_d   = acc_q;
    if (start_acc) begin
      acc_d = '0;
    end else if (pop_valid) begin
      acc_d = acc_sum[POP] ? '1 : acc_sum[POP-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_q    <= '0;
      thr_q  <= '0;
      addr_q <= '0;
      acc_q  <= '0;
      vld_q  <= '0;
    end else begin
      k_q    <= k_d;
      thr_q  <= thr_d;
      addr_q <= addr_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
    end
  end

  xnor_popcount_stage #(
    .N (N)
  ) u_pop (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (vld_q[RD_LAT-1]),
    .x         (rd_x),
    .w         (rd_w),
    .out_valid (pop_valid),
    .count     (pop_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_xnor_neuron_sequencer.sv
// tb_xnor_neuron_sequencer -- directed vectors with a result scoreboard and latency/read checks.
// rev 1.0
`default_nettype none

module tb_xnor_neuron_sequencer;

  localparam int N  = 256;
  localparam int AW = 3;
  localparam int POP = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic [AW:0]    num_chunks;
  logic [POP-1:0] threshold;
  logic           busy;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [N-1:0]   rd_x;
  logic [N-1:0]   rd_w;
  logic           out_valid;
  logic           out_ready;
  logic           out_bit;
  logic [POP-1:0] out_sum;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] mem_x [8];
  logic [N-1:0] mem_w [8];
  logic [AW:0]  p1 = '0;
  logic [AW:0]  p2 = '0;

  logic [POP:0] sb_q [$];

  always #5 clk = ~clk;

  xnor_neuron_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .num_chunks (num_chunks),
    .threshold  (threshold),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_x       (rd_x),
    .rd_w       (rd_w),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_sum    (out_sum)
  );

  // Two-cycle read memory; unaffected by DUT reset so stale returns keep arriving.
  always @(posedge clk) begin
    p1 <= {rd_en, rd_addr};
    p2 <= p1;
  end

  always @* begin
    if (p2[AW]) begin
      rd_x = mem_x[p2[AW-1:0]];
      rd_w = mem_w[p2[AW-1:0]];
    end else begin
      rd_x = '1;
      rd_w = '1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [POP:0] e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e[POP-1:0]));
        check("out_bit", 32'(out_bit), 32'(e[POP]));
      end
    end
  end

  task automatic fill(input logic [N-1:0] x, input logic [N-1:0] w);
    for (int i = 0; i < 8; i++) begin
      mem_x[i] = x;
      mem_w[i] = w;
    end
  endtask

  task automatic run_eval(input int k, input int thr, input int exp_sum, input int exp_bit,
                          input int exp_reads, input int exp_lat);
    int n, reads, lat;
    @(negedge clk);
    start      = 1'b1;
    num_chunks = (AW+1)'(k);
    threshold  = POP'(thr);
    sb_q.push_back({1'(exp_bit), POP'(exp_sum)});
    @(negedge clk);
    start = 1'b0;
    n = 1; reads = 0; lat = 0;
    while (n < 200 && lat == 0) begin
      if (rd_en) begin
        check("rd_addr", 32'(rd_addr), 32'(reads));
        reads++;
      end
      if (out_valid) lat = n;
      if (lat == 0) begin
        @(negedge clk);
        n++;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("reads", 32'(reads), 32'(exp_reads));
    @(negedge clk);
    check("busy_after_hs", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, reads;
    rstn = 1'b0; start = 1'b0; num_chunks = '0; threshold = '0; out_ready = 1'b1;
    fill('0, '0);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    rstn = 1'b1;

    // single all-match chunk
    fill('1, '1);
    run_eval(1, 255, 256, 1, 1, 5);

    // all mismatch, strict compare against zero
    for (int i = 0; i < 8; i++) begin
      mem_x[i] = {8{$urandom()}};
      mem_w[i] = ~mem_x[i];
    end
    run_eval(8, 0, 0, 0, 8, 12);

    // 128 matches per chunk around the threshold
    fill('1, {{128{1'b1}}, {128{1'b0}}});
    run_eval(4, 512, 512, 0, 4, 8);
    run_eval(4, 511, 512, 1, 4, 8);

    // K=0 and clamped K=12
    run_eval(0, 0, 0, 0, 0, 1);
    fill('1, '1);
    run_eval(12, 0, 2048, 1, 8, 12);

    // backpressure in RESULT with an ignored start
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; num_chunks = 4'd2; threshold = 16'd0;
    sb_q.push_back({1'b1, 16'd512});
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      start      = (i == 3);
      num_chunks = 4'd1;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'd512);
      check("hold_bit", 32'(out_bit), 32'd1);
      check("hold_rd_en", 32'(rd_en), 32'd0);
    end
    start = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_after_hold", 32'(busy), 32'd0);
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reads += int'(rd_en) + int'(busy);
    end
    check("start_not_queued", 32'(reads), 32'd0);

    // reset mid-issue, then a fresh evaluation with stale data still returning
    fill('1, '1);
    @(negedge clk);
    start = 1'b1; num_chunks = 4'd8; threshold = 16'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0; reads = 0;
    while (reads < 3 && n < 50) begin
      if (rd_en) reads++;
      if (reads < 3) begin
        @(negedge clk);
        n++;
      end
    end
    rstn = 1'b0;
    @(negedge clk);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_rd_en", 32'(rd_en), 32'd0);
    check("mrst_rd_addr", 32'(rd_addr), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_sum", 32'(out_sum), 32'd0);
    check("mrst_out_bit", 32'(out_bit), 32'd0);
    rstn = 1'b1;
    run_eval(2, 0, 512, 1, 2, 6);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
